// File: rtl/ram_dp_sr_rw_clr.sv
// Dual-port RAM (port A read/write, port B read-only) with synchronous read,
// selectable read-during-write behaviour, optional output register and a clear engine.
module ram_dp_sr_rw_clr #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter int                    RD_MODE    = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  a_cs,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_cs,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_in_range, b_in_range;
  logic                  a_rd, a_wr, b_rd, coll;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] a_dout1_q, a_dout1_d, b_dout1_q, b_dout1_d;
  logic                  a_valid1_q, a_valid1_d, b_valid1_q, b_valid1_d;
  logic                  coll1_q, coll1_d;

  assign busy = (state_q == ST_CLEAR);

  // Sweep runs from address 0 up to DEPTH-1, then returns to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    a_in_range = ({1'b0, a_addr} < DEPTH_W);
    b_in_range = ({1'b0, b_addr} < DEPTH_W);
    a_rd       = !busy && a_cs && !a_we;
    a_wr       = !busy && a_cs && a_we && a_in_range;
    b_rd       = !busy && b_cs;
    coll       = a_wr && b_rd && (a_addr == b_addr);

    a_rdata = a_in_range ? mem[a_addr[IDX_W-1:0]] : '0;
    if (!b_in_range)
      b_rdata = '0;
    else if (coll && (RD_MODE != 0))
      b_rdata = a_din;
    else
      b_rdata = mem[b_addr[IDX_W-1:0]];

    // The clear engine owns the write port for the whole sweep.
    mem_we    = busy || a_wr;
    mem_waddr = busy ? ptr_q : a_addr[IDX_W-1:0];
    mem_wdata = busy ? CLR_VALUE : a_din;

    a_dout1_d  = a_rd ? a_rdata : a_dout1_q;
    b_dout1_d  = b_rd ? b_rdata : b_dout1_q;
    a_valid1_d = a_rd;
    b_valid1_d = b_rd;
    coll1_d    = coll;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      a_dout1_q  <= '0;
      b_dout1_q  <= '0;
      a_valid1_q <= 1'b0;
      b_valid1_q <= 1'b0;
      coll1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_dout1_q  <= a_dout1_d;
      b_dout1_q  <= b_dout1_d;
      a_valid1_q <= a_valid1_d;
      b_valid1_q <= b_valid1_d;
      coll1_q    <= coll1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] a_dout2_q, a_dout2_d, b_dout2_q, b_dout2_d;
    logic                  a_valid2_q, b_valid2_q, coll2_q;

    always_comb begin
      a_dout2_d = a_valid1_q ? a_dout1_q : a_dout2_q;
      b_dout2_d = b_valid1_q ? b_dout1_q : b_dout2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_dout2_q  <= '0;
        b_dout2_q  <= '0;
        a_valid2_q <= 1'b0;
        b_valid2_q <= 1'b0;
        coll2_q    <= 1'b0;
      end else begin
        a_dout2_q  <= a_dout2_d;
        b_dout2_q  <= b_dout2_d;
        a_valid2_q <= a_valid1_q;
        b_valid2_q <= b_valid1_q;
        coll2_q    <= coll1_q;
      end
    end

    assign a_dout    = a_dout2_q;
    assign b_dout    = b_dout2_q;
    assign a_valid   = a_valid2_q;
    assign b_valid   = b_valid2_q;
    assign collision = coll2_q;
  end else begin : g_no_out_reg
    assign a_dout    = a_dout1_q;
    assign b_dout    = b_dout1_q;
    assign a_valid   = a_valid1_q;
    assign b_valid   = b_valid1_q;
    assign collision = coll1_q;
  end

endmodule

// File: tb/tb_ram_dp_sr_rw_clr.sv
// Bench for ram_dp_sr_rw_clr: two configurations share one stimulus stream and
// are each checked by a scoreboard fed from a word-level reference model.
module tb_ram_dp_sr_rw_clr;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       coll;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       a_cs, a_we, b_cs;
  logic [7:0] a_addr, a_din, b_addr;

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input int inst, input string name,
                             input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL inst%0d %s actual=%0h required=%0h at %0t", inst, name, act, req, $time);
    end
  endtask

  // Instance 0: read-first, no output register. Instance 1: write-first,
  // output register, DEPTH below the address range and a non-zero clear value.
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int         DEP  = (g == 0) ? 256 : 200;
    localparam int         RDM  = (g == 0) ? 0 : 1;
    localparam int         OREG = (g == 0) ? 0 : 1;
    localparam logic [7:0] CLRV = (g == 0) ? 8'h00 : 8'hC3;
    localparam int         LAT  = OREG + 1;

    logic       busy_o, a_valid_o, b_valid_o, coll_o;
    logic [7:0] a_dout_o, b_dout_o;

    ram_dp_sr_rw_clr #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEP),
      .RD_MODE(RDM), .OUT_REG(OREG), .CLR_VALUE(CLRV)
    ) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy_o),
      .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout_o), .a_valid(a_valid_o),
      .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout_o), .b_valid(b_valid_o),
      .collision(coll_o)
    );

    logic [7:0] mem_m [256];
    logic       busy_m = 1'b1;
    int         rem_m  = DEP;
    int         cyc    = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic       hit, exp_av, exp_bv, exp_coll;
    logic [7:0] d;

    // Model steps once per edge (or on reset), then the monitor compares just after.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_m = 1'b1;
        rem_m  = DEP;
        qa.delete();
        qb.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        for (int i = 0; i < 256; i++) mem_m[i] = CLRV;
      end else begin
        cyc++;
        if (busy_m) begin
          rem_m--;
          if (rem_m == 0) busy_m = 1'b0;
        end else begin
          if (a_cs && !a_we) begin
            d = (int'(a_addr) < DEP) ? mem_m[a_addr] : 8'h00;
            qa.push_back('{cyc + LAT - 1, d, 1'b0});
          end
          if (b_cs) begin
            hit = a_cs && a_we && (int'(a_addr) < DEP) && (a_addr == b_addr);
            if (int'(b_addr) >= DEP) d = 8'h00;
            else if (hit && RDM == 1) d = a_din;
            else d = mem_m[b_addr];
            qb.push_back('{cyc + LAT - 1, d, hit});
          end
          if (a_cs && a_we && int'(a_addr) < DEP) mem_m[a_addr] = a_din;
          if (clr) begin
            busy_m = 1'b1;
            rem_m  = DEP;
            for (int i = 0; i < 256; i++) mem_m[i] = CLRV;
          end
        end
      end
      #1;
      exp_av   = (qa.size() != 0) && (qa[0].due == cyc) && !rst;
      exp_bv   = (qb.size() != 0) && (qb[0].due == cyc) && !rst;
      exp_coll = 1'b0;
      if (exp_av) begin
        last_a = qa[0].data;
        void'(qa.pop_front());
      end
      if (exp_bv) begin
        last_b   = qb[0].data;
        exp_coll = qb[0].coll;
        void'(qb.pop_front());
      end
      checkOutput(g, "busy", 8'(busy_o), 8'(busy_m));
      checkOutput(g, "a_valid", 8'(a_valid_o), 8'(exp_av));
      checkOutput(g, "a_dout", a_dout_o, last_a);
      checkOutput(g, "b_valid", 8'(b_valid_o), 8'(exp_bv));
      checkOutput(g, "b_dout", b_dout_o, last_b);
      checkOutput(g, "collision", 8'(coll_o), 8'(exp_coll));
    end
  end

  task automatic applyStimulus(input logic acs, input logic awe, input logic [7:0] aad,
                               input logic [7:0] adin, input logic bcs,
                               input logic [7:0] bad, input logic cl);
    @(negedge clk);
    a_cs   = acs;
    a_we   = awe;
    a_addr = aad;
    a_din  = adin;
    b_cs   = bcs;
    b_addr = bad;
    clr    = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst  = 1'b1;
    a_cs = 1'b0;
    b_cs = 1'b0;
    clr  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0;
    a_cs = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_din = 8'h00;
    b_cs = 1'b0; b_addr = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(258);

    // Full readback of the cleared array on port B.
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 1'b0);

    // Random fill, then interleaved readback on both ports.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b1, 8'(i), 8'($urandom), 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 8'(255 - i), 1'b0);

    // Same-address collision, then same-address reads on both ports.
    applyStimulus(1'b1, 1'b1, 8'h10, 8'hAA, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h55, 1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h10, 1'b0);

    // Clear request with traffic and a second clr during the sweep.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 270; i++)
      applyStimulus(1'b1, 1'(i % 2), 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 1'(i == 50));
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 8'h80, 1'b0);

    // Reset part way through a sweep.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(100);
    pulseReset();
    idle(260);

    // Out-of-range write and read, then check the in-range words of the smaller array.
    applyStimulus(1'b1, 1'b1, 8'd210, 8'hFF, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd210, 8'h00, 1'b1, 8'd210, 1'b0);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 8'(199 - i), 1'b0);

    // Random mixed traffic, half of it on a narrow window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] aa, ba;
      if (i % 2 == 0) begin
        aa = 8'($urandom_range(0, 15));
        ba = 8'($urandom_range(0, 15));
      end else begin
        aa = 8'($urandom);
        ba = 8'($urandom);
      end
      applyStimulus(1'($urandom), 1'($urandom), aa, 8'($urandom), 1'($urandom), ba,
                    1'($urandom_range(0, 199) == 0));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
